// File: rtl/ymat_row_arbiter_if.sv
// Bundle of requester, SRAM and response signals for the Y-matrix row arbiter.
interface ymat_row_arbiter_if #(
  parameter int ELEM_W = 16
);
  logic                  r0_req;
  logic [15:0]           r0_idx;
  logic                  r0_gnt;
  logic                  r1_req;
  logic [15:0]           r1_idx;
  logic                  r1_gnt;
  logic                  inv;
  logic                  sram_rd_en;
  logic [10:0]           sram_addr;
  logic [16*ELEM_W-1:0]  sram_rdata;
  logic                  rsp_valid;
  logic                  rsp_id;
  logic [ELEM_W-1:0]     rsp_data;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output r0_req, r0_idx, r1_req, r1_idx, inv, sram_rdata,
    input  r0_gnt, r1_gnt, sram_rd_en, sram_addr, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    input  r0_req, r0_idx, r1_req, r1_idx, inv, sram_rdata,
    output r0_gnt, r1_gnt, sram_rd_en, sram_addr, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/ymat_row_arbiter.sv
// Round-robin arbiter sharing the Y-matrix SRAM read port between two requesters.
// Optional YMR_LINE_CACHE_EN enables the one-line buffer hit path.
module ymat_row_arbiter #(
  parameter int ELEM_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic               clock,
  input  logic               reset,
  ymat_row_arbiter_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HIT  = 3'd1,
    ERR  = 3'd2,
    RD   = 3'd3,
    WAIT = 3'd4,
    FILL = 3'd5
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  function automatic logic [ELEM_W-1:0] sel_elem(input logic [16*ELEM_W-1:0] line,
                                                 input logic [3:0] k);
    logic [ELEM_W-1:0] e;
    e = '0;
    for (int i = 0; i < 16; i++) begin
      if (k == 4'(i)) e = line[i*ELEM_W +: ELEM_W];
    end
    return e;
  endfunction

  state_t                state_r, state_nxt;
  logic [15:0]           idx_r, idx_nxt;
  logic                  id_r, id_nxt;
  logic                  last_r, last_nxt;
  logic                  busy_r, busy_nxt;
  logic                  gnt0_r, gnt0_nxt;
  logic                  gnt1_r, gnt1_nxt;
  logic                  rd_en_r, rd_en_nxt;
  logic [10:0]           addr_r, addr_nxt;
  logic [1:0]            cnt_r, cnt_nxt;
  logic                  rsp_valid_r, rsp_valid_nxt;
  logic                  rsp_id_r, rsp_id_nxt;
  logic [ELEM_W-1:0]     rsp_data_r, rsp_data_nxt;
  logic                  rsp_err_r, rsp_err_nxt;
  logic [16*ELEM_W-1:0]  line_r, line_nxt;
  logic                  win_s;
  logic                  hit_s;
  logic [10:0]           line_s;
  logic [3:0]            k_s;

  assign line_s = idx_r[14:4];
  assign k_s    = idx_r[3:0];

`ifdef YMR_LINE_CACHE_EN
  logic                  valid_r, valid_nxt;
  logic [10:0]           tag_r, tag_nxt;
  logic                  inv_seen_r, inv_seen_nxt;
  assign hit_s = valid_r && (tag_r == line_s) && !bus.inv;
`else
  logic                  unused_inv;
  assign unused_inv = bus.inv;
  assign hit_s      = 1'b0;
`endif

  // Round-robin winner: on a tie the requester not served last wins.
  always_comb begin
    if (bus.r0_req && bus.r1_req) begin
      win_s = ~last_r;
    end else if (bus.r1_req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state_r;
    idx_nxt       = idx_r;
    id_nxt        = id_r;
    last_nxt      = last_r;
    busy_nxt      = busy_r;
    gnt0_nxt      = 1'b0;
    gnt1_nxt      = 1'b0;
    rd_en_nxt     = 1'b0;
    addr_nxt      = addr_r;
    cnt_nxt       = cnt_r;
    rsp_valid_nxt = 1'b0;
    rsp_id_nxt    = rsp_id_r;
    rsp_data_nxt  = rsp_data_r;
    rsp_err_nxt   = rsp_err_r;
    line_nxt      = line_r;
`ifdef YMR_LINE_CACHE_EN
    valid_nxt     = valid_r & ~bus.inv;
    tag_nxt       = tag_r;
    inv_seen_nxt  = inv_seen_r | (bus.inv & ((state_r == RD) | (state_r == WAIT)));
`endif
    case (state_r)
      IDLE: begin
        if (busy_r) begin
`ifdef YMR_LINE_CACHE_EN
          inv_seen_nxt = 1'b0;
`endif
          if (idx_r[15]) begin
            state_nxt     = ERR;
            busy_nxt      = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_id_nxt    = id_r;
            rsp_err_nxt   = 1'b1;
            rsp_data_nxt  = '0;
          end else if (hit_s) begin
            state_nxt     = HIT;
            busy_nxt      = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_id_nxt    = id_r;
            rsp_err_nxt   = 1'b0;
            rsp_data_nxt  = sel_elem(line_r, k_s);
          end else begin
            state_nxt = RD;
            rd_en_nxt = 1'b1;
            addr_nxt  = line_s;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RD: begin
        state_nxt = WAIT;
        cnt_nxt   = LAT_M1;
      end
      WAIT: begin
        if (cnt_r == 2'd0) begin
          state_nxt     = FILL;
          busy_nxt      = 1'b0;
          line_nxt      = bus.sram_rdata;
          rsp_valid_nxt = 1'b1;
          rsp_id_nxt    = id_r;
          rsp_err_nxt   = 1'b0;
          rsp_data_nxt  = sel_elem(bus.sram_rdata, k_s);
`ifdef YMR_LINE_CACHE_EN
          // An invalidate seen while the read was in flight leaves the line unusable.
          valid_nxt    = ~(inv_seen_r | bus.inv);
          tag_nxt      = line_s;
          inv_seen_nxt = 1'b0;
`endif
        end else begin
          cnt_nxt = cnt_r - 2'd1;
        end
      end
      HIT, ERR, FILL: state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
    if (!busy_r && (bus.r0_req || bus.r1_req)) begin
      gnt0_nxt  = ~win_s;
      gnt1_nxt  = win_s;
      last_nxt  = win_s;
      id_nxt    = win_s;
      busy_nxt  = 1'b1;
      idx_nxt   = win_s ? bus.r1_idx : bus.r0_idx;
      state_nxt = IDLE;
    end else begin
      last_nxt = last_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      idx_r       <= 16'd0;
      id_r        <= 1'b0;
      last_r      <= 1'b1;
      busy_r      <= 1'b0;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      addr_r      <= 11'd0;
      cnt_r       <= 2'd0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_data_r  <= '0;
      rsp_err_r   <= 1'b0;
      line_r      <= '0;
`ifdef YMR_LINE_CACHE_EN
      valid_r     <= 1'b0;
      tag_r       <= 11'd0;
      inv_seen_r  <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt;
      idx_r       <= idx_nxt;
      id_r        <= id_nxt;
      last_r      <= last_nxt;
      busy_r      <= busy_nxt;
      gnt0_r      <= gnt0_nxt;
      gnt1_r      <= gnt1_nxt;
      rd_en_r     <= rd_en_nxt;
      addr_r      <= addr_nxt;
      cnt_r       <= cnt_nxt;
      rsp_valid_r <= rsp_valid_nxt;
      rsp_id_r    <= rsp_id_nxt;
      rsp_data_r  <= rsp_data_nxt;
      rsp_err_r   <= rsp_err_nxt;
      line_r      <= line_nxt;
`ifdef YMR_LINE_CACHE_EN
      valid_r     <= valid_nxt;
      tag_r       <= tag_nxt;
      inv_seen_r  <= inv_seen_nxt;
`endif
    end
  end

  assign bus.r0_gnt     = gnt0_r;
  assign bus.r1_gnt     = gnt1_r;
  assign bus.sram_rd_en = rd_en_r;
  assign bus.sram_addr  = addr_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_ymat_row_arbiter.sv
// Directed self-checking bench for ymat_row_arbiter; adapts expectations to RD_LAT
// and to whether YMR_LINE_CACHE_EN is defined.
module tb_ymat_row_arbiter;
  parameter int RD_LAT = 1;
`ifdef YMR_LINE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  ymat_row_arbiter_if #(.ELEM_W(16)) bus ();

  ymat_row_arbiter #(.ELEM_W(16), .RD_LAT(RD_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model: element e of line a is {e, 0, a}, except line 0x012 element 3.
  function automatic logic [255:0] gen_line(input logic [10:0] a);
    logic [255:0] l;
    logic [15:0]  w;
    for (int e = 0; e < 16; e++) begin
      w = {4'(e), 1'b0, a};
      if (a == 11'h012 && e == 3) w = 16'hBEEF;
      l[e*16 +: 16] = w;
    end
    return l;
  endfunction

  logic        pv [1:4];
  logic [10:0] pa [1:4];
  always @(posedge clock) begin
    pv[1] <= bus.sram_rd_en;
    pa[1] <= bus.sram_addr;
    for (int i = 2; i <= 4; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  always_comb bus.sram_rdata = (pv[RD_LAT] === 1'b1) ? gen_line(pa[RD_LAT]) : {16{16'hDEAD}};

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  task automatic access(input bit id, input logic [15:0] idx, input bit hit, input bit err,
                        input logic [15:0] data, input bit inv_rd, input string tag);
    bit          got;
    bit          done;
    int          lat;
    int          rd_cnt;
    int          rd_off;
    int          extra;
    logic [10:0] rd_addr;
    if (id) begin
      bus.r1_req = 1'b1; bus.r1_idx = idx;
    end else begin
      bus.r0_req = 1'b1; bus.r0_idx = idx;
    end
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clock); #1;
      got = id ? bus.r1_gnt : bus.r0_gnt;
    end
    chk({tag, "_gnt"}, got, 1);
    chk({tag, "_other_gnt"}, id ? bus.r0_gnt : bus.r1_gnt, 0);
    chk({tag, "_busy_c"}, bus.busy, 1);
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    done = 1'b0; lat = 0; rd_cnt = 0; rd_off = 0; extra = 0; rd_addr = 11'd0;
    for (int c = 1; c <= 20 && !done; c++) begin
      @(posedge clock); #1;
      if (bus.inv) bus.inv = 1'b0;
      if (bus.sram_rd_en) begin
        rd_cnt++; rd_off = c; rd_addr = bus.sram_addr;
        if (inv_rd) bus.inv = 1'b1;
      end
      if (bus.r0_gnt || bus.r1_gnt) extra++;
      if (bus.rsp_valid) begin
        done = 1'b1; lat = c;
      end
    end
    chk({tag, "_lat"}, lat, (err || hit) ? 1 : 2 + RD_LAT);
    chk({tag, "_rd_cnt"}, rd_cnt, (err || hit) ? 0 : 1);
    if (!(err || hit)) begin
      chk({tag, "_rd_off"}, rd_off, 1);
      chk({tag, "_rd_addr"}, rd_addr, idx[14:4]);
    end
    chk({tag, "_rsp_id"}, bus.rsp_id, id);
    chk({tag, "_rsp_data"}, bus.rsp_data, data);
    chk({tag, "_rsp_err"}, bus.rsp_err, err);
    chk({tag, "_busy_rsp"}, bus.busy, 0);
    chk({tag, "_gnt_busy"}, extra, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ng;
    int  nr;
    int  last_rsp;
    int  cnt;
    bit  exp_id;
    bit  cur;
    bit  outst;
    bit  got;
    tests = 0; fails = 0;
    reset = 1'b0;
    bus.r0_req = 1'b0; bus.r0_idx = 16'd0;
    bus.r1_req = 1'b0; bus.r1_idx = 16'd0;
    bus.inv = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ctl", {bus.r0_gnt, bus.r1_gnt, bus.sram_rd_en, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.busy}, 0);
    chk("rst_addr", bus.sram_addr, 0);
    chk("rst_data", bus.rsp_data, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("idle_ctl", {bus.r0_gnt, bus.r1_gnt, bus.sram_rd_en, bus.rsp_valid, bus.busy}, 0);

    access(1'b0, 16'h0123, 1'b0, 1'b0, 16'hBEEF, 1'b0, "miss0");
    access(1'b1, 16'h012A, CACHE, 1'b0, 16'hA012, 1'b0, "hit1");

    // Both requesters continuously active on distinct lines.
    bus.r0_idx = 16'h0237; bus.r1_idx = 16'h0341;
    bus.r0_req = 1'b1; bus.r1_req = 1'b1;
    ng = 0; nr = 0; last_rsp = 0; exp_id = 1'b0; cur = 1'b0; outst = 1'b0;
    for (int c = 0; c < 100 && nr < 4; c++) begin
      @(posedge clock); #1;
      if (bus.r0_gnt || bus.r1_gnt) begin
        chk("rr_order", bus.r1_gnt, exp_id);
        chk("rr_both", bus.r0_gnt & bus.r1_gnt, 0);
        chk("rr_outstanding", outst, 0);
        if (ng > 0) chk("rr_gap", c - last_rsp, 1);
        outst = 1'b1; cur = bus.r1_gnt; exp_id = ~exp_id; ng++;
      end
      if (bus.rsp_valid) begin
        chk("rr_rsp_id", bus.rsp_id, cur);
        chk("rr_rsp_data", bus.rsp_data, cur ? 16'h1034 : 16'h7023);
        outst = 1'b0; last_rsp = c; nr++;
      end
    end
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    chk("rr_count", nr, 4);

    access(1'b0, 16'h0126, 1'b0, 1'b0, 16'h6012, 1'b0, "reload");
    access(1'b1, 16'h0127, CACHE, 1'b0, 16'h7012, 1'b0, "hit2");
    bus.inv = 1'b1;
    @(posedge clock); #1;
    bus.inv = 1'b0;
    access(1'b0, 16'h0125, 1'b0, 1'b0, 16'h5012, 1'b0, "inv_miss");
    access(1'b0, 16'h0128, 1'b0, 1'b0, 16'h8012, 1'b1, "inv_rd");
    access(1'b1, 16'h0129, 1'b0, 1'b0, 16'h9012, 1'b0, "after_inv");
    access(1'b0, 16'h012B, CACHE, 1'b0, 16'hB012, 1'b0, "rehit");
    access(1'b1, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b0, "err");

    // Reset while a miss is waiting on the SRAM.
    bus.r0_idx = 16'h0500; bus.r0_req = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clock); #1;
      got = bus.r0_gnt;
    end
    bus.r0_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(posedge clock); #1;
      got = bus.sram_rd_en;
    end
    chk("abort_rd", got, 1);
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    chk("abort_ctl", {bus.r0_gnt, bus.r1_gnt, bus.sram_rd_en, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.busy}, 0);
    chk("abort_addr", bus.sram_addr, 0);
    chk("abort_data", bus.rsp_data, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (bus.rsp_valid || bus.busy) cnt++;
    end
    chk("abort_quiet", cnt, 0);

    access(1'b0, 16'h012B, 1'b0, 1'b0, 16'hB012, 1'b0, "post_rst");
    access(1'b0, 16'h0040, 1'b0, 1'b0, 16'h0004, 1'b0, "line4_a");
    access(1'b0, 16'h0040, CACHE, 1'b0, 16'h0004, 1'b0, "line4_b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ymat_row_arbiter.md
Name: ymat_row_arbiter

Overview:
- Shares the single Y-matrix SRAM read port between two requesters (e.g. the mismatch and Jacobian engines).
- Converts a 16-bit Y-matrix row index into an SRAM line address (index / 16) and an element offset (index mod 16).
- Round-robin arbitration; at most one outstanding read.
- A one-line buffer serves repeat accesses to the same SRAM line without a new SRAM read.

Parameters:
- ELEM_W, 16, width of one Y-matrix element.
- RD_LAT, 1, SRAM read latency in cycles (1..4).

Ports:
- clock  input  1  sole clock; all logic is posedge.
- reset  input  1  asynchronous, active-low reset.
- r0_req  input  1  requester 0 request; held until r0_gnt.
- r0_idx  input  16  requester 0 row index.
- r0_gnt  output  1  one-cycle pulse; r0_idx sampled.
- r1_req  input  1  requester 1 request.
- r1_idx  input  16  requester 1 row index.
- r1_gnt  output  1  one-cycle pulse; r1_idx sampled.
- inv  input  1  invalidate line buffer (SRAM contents changed).
- sram_rd_en  output  1  one-cycle SRAM read strobe.
- sram_addr  output  11  SRAM line address.
- sram_rdata  input  16*ELEM_W  SRAM line data, valid RD_LAT cycles after sram_rd_en.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_id  output  1  requester served (0/1).
- rsp_data  output  ELEM_W  selected element.
- rsp_err  output  1  index out of range.
- busy  output  1  a transaction is in flight.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0; FSM IDLE; line-buffer valid 0; tag 0.
  - Round-robin pointer set so r0 wins the first tie.
- All outputs are registered.
- FSM states: IDLE -> (HIT | ERR | RD) ; RD -> WAIT ; WAIT -> FILL ; HIT/ERR/FILL -> IDLE.
- IDLE:
  - If any req, assert gnt for the winner in cycle C.
  - Latch idx, id; busy=1 from cycle C.
  - Arbitration: single requester wins. On tie, the requester not served last wins; pointer updates at each grant.
- Address rules:
  - line = idx[14:4] (11 bits); offset k = idx[3:0].
  - Element k = sram_rdata[k*ELEM_W +: ELEM_W].
- idx[15]=1 -> ERR:
  - No SRAM access.
  - Cycle C+1: rsp_valid=1, rsp_err=1, rsp_data=0.
- Buffer valid and tag==line and inv=0 in cycle C -> HIT:
  - Cycle C+1: rsp_valid=1 with element k from the buffer.
- Otherwise -> RD (miss):
  - Cycle C+1: sram_rd_en=1, sram_addr=line.
  - WAIT counts RD_LAT cycles.
  - Cycle C+1+RD_LAT: sram_rdata is captured into the buffer, tag=line, valid=1.
  - Cycle C+2+RD_LAT: rsp_valid=1, data from the captured line.
- busy deasserts with rsp_valid. The earliest next gnt is in the cycle after rsp_valid.
- gnt is never asserted while busy=1. Requests arriving while busy wait, no loss.
- inv:
  - Clears valid on the next edge.
  - inv in the same cycle as a hit check forces a miss.
  - inv during RD/WAIT/FILL: the fill completes and the response is returned, but valid stays 0 after the fill.
- sram_addr holds its last value when sram_rd_en=0.
- rsp_id/rsp_data/rsp_err hold until the next response.
- Reset mid-transaction: immediate abort, no response, buffer invalid.

Optional Feature:
- Macro: YMR_LINE_CACHE_EN.
- Defined: line buffer and HIT path as described.
- Undefined:
  - Buffer tag compare removed; every in-range access takes the miss path, rsp_valid at C+2+RD_LAT.
  - inv is ignored.
  - Response data is still taken from the captured line register.

Test Plan:
- Reset then idle: all outputs 0; assert r0_req idx=0x0123 -> r0_gnt at C, sram_rd_en at C+1 with sram_addr=0x012. With sram_rdata element 3=0xBEEF: rsp_valid at C+3 (RD_LAT=1), rsp_id=0, rsp_data=0xBEEF, rsp_err=0.
- After the above, r1_req idx=0x012A -> hit, no sram_rd_en. rsp_valid one cycle after r1_gnt, rsp_id=1, rsp_data=element 10.
- r0_req and r1_req both high continuously with idx in distinct lines -> grants alternate r0,r1,r0,r1. Each grant follows the prior rsp_valid by one cycle; never two outstanding.
- inv pulsed one cycle before a same-line r0 request (idx=0x0125) -> treated as miss, sram_rd_en with sram_addr=0x012. inv during WAIT -> next same-line access misses again.
- r1_idx=0x8000 -> r1_gnt, no sram_rd_en, rsp_err=1 and rsp_data=0 at C+1. Reset asserted during WAIT of a miss -> all outputs 0 at once, no rsp_valid afterwards.
- RD_LAT=3, YMR_LINE_CACHE_EN undefined: two back-to-back r0 reads of idx=0x0040 each produce sram_rd_en=1 with sram_addr=0x004 and rsp_valid at C+5.
